pipe_stage_reg: RTL and testbench

- Parametrised elastic pipeline stage register, the generalised successor of the fixed IF/ID latch.
- Carries an arbitrary DATA_W payload (e.g. {pc, instr}) between any two pipeline stages using a valid/ready handshake.
- A two-entry skid buffer keeps ready_o registered, so there is no combinational ready path.
- Keeps the legacy stall_i and flush_i controls, so hazard and branch units connect unchanged.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_stage_reg.sv | 99 +++++++++
 tb/tb_pipe_stage_reg.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for elastic pipeline stage registers.
// The state encoding is also the raw occupancy count for the legal states.
package pipe_pkg;

  localparam int OCC_W  = 2;
  localparam int IFID_W = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      HALF:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready stage with a two-entry skid: 1-cycle latency, 1 item/cycle sustained.
// ready_o depends only on the state register, so upstream never sees a combinational ready path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = IFID_W,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [OCC_W-1:0]  occupancy_o
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;
  logic              main_from_in;
  logic              main_from_skid;
  logic              skid_from_in;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i & ~stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (in_fire) state_nxt = HALF;
      end
      HALF: begin
        if (in_fire && !out_fire)      state_nxt = FULL;
        else if (!in_fire && out_fire) state_nxt = EMPTY;
      end
      FULL: begin
        if (out_fire) state_nxt = HALF;
      end
      // The unused encoding drops back to a clean empty stage.
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    case (state)
      EMPTY:   main_from_in   = in_fire;
      HALF: begin
        main_from_in = in_fire & out_fire;
        skid_from_in = in_fire & ~out_fire;
      end
      FULL:    main_from_skid = out_fire;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      main_q <= RESET_DATA;
      skid_q <= RESET_DATA;
    end else begin
      if (main_from_in) begin
        main_q <= data_i;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (skid_from_in) begin
        skid_q <= data_i;
      end
    end
  end

  always_comb begin
    valid_o     = (state != EMPTY);
    ready_o     = (state != FULL);
    occupancy_o = occ_of(state);
    data_o      = main_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scenario checks plus a queue-model scoreboard for random traffic.
module tb_pipe_stage_reg;

  localparam int          W  = 64;
  localparam logic [63:0] RD = 64'hDEAD;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         stall;
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] data_in;
  logic         valid_out;
  logic         ready_in;
  logic [W-1:0] data_out;
  logic [1:0]   occ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(W), .RESET_DATA(RD)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .stall_i     (stall),
    .valid_i     (valid_in),
    .ready_o     (ready_out),
    .data_i      (data_in),
    .valid_o     (valid_out),
    .ready_i     (ready_in),
    .data_o      (data_out),
    .occupancy_o (occ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; stall = 0; valid_in = 0; ready_in = 1; data_in = '0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; stall = 0; valid_in = 1; ready_in = 1; data_in = 64'h5;
    tick(); tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", valid_out); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h want=1", ready_out); end
    total++; if (data_out !== RD) begin bad++; $display("FAIL reset_data got=%0h want=%0h", data_out, RD); end
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occ); end
    idle();
  endtask

  task automatic test_streaming();
    logic [63:0] vals [3];
    vals[0] = 64'h10; vals[1] = 64'h14; vals[2] = 64'h18;
    idle();
    for (int i = 0; i < 3; i++) begin
      valid_in = 1; data_in = vals[i];
      tick();
      total++; if (data_out !== vals[i] || valid_out !== 1'b1 || occ !== 2'd1) begin
        bad++; $display("FAIL stream_%0d got data=%0h v=%0b occ=%0d want data=%0h v=1 occ=1", i, data_out, valid_out, occ, vals[i]);
      end
    end
    valid_in = 0;
    tick();
    total++; if (valid_out !== 1'b0 || occ !== 2'd0 || data_out !== 64'h18) begin
      bad++; $display("FAIL stream_drain got v=%0b occ=%0d data=%0h want v=0 occ=0 data=18", valid_out, occ, data_out);
    end
  endtask

  task automatic test_backpressure();
    idle(); ready_in = 0;
    valid_in = 1; data_in = 64'hA0; tick();
    total++; if (occ !== 2'd1 || ready_out !== 1'b1 || data_out !== 64'hA0) begin
      bad++; $display("FAIL bp_first got occ=%0d rdy=%0b data=%0h want occ=1 rdy=1 data=a0", occ, ready_out, data_out);
    end
    data_in = 64'hA4; tick();
    total++; if (occ !== 2'd2 || ready_out !== 1'b0 || data_out !== 64'hA0) begin
      bad++; $display("FAIL bp_full got occ=%0d rdy=%0b data=%0h want occ=2 rdy=0 data=a0", occ, ready_out, data_out);
    end
    valid_in = 0; ready_in = 1; tick();
    total++; if (occ !== 2'd1 || data_out !== 64'hA4 || valid_out !== 1'b1) begin
      bad++; $display("FAIL bp_drain1 got occ=%0d data=%0h v=%0b want occ=1 data=a4 v=1", occ, data_out, valid_out);
    end
    tick();
    total++; if (occ !== 2'd0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL bp_drain2 got occ=%0d v=%0b want occ=0 v=0", occ, valid_out);
    end
  endtask

  task automatic test_stall();
    idle();
    valid_in = 1; data_in = 64'hC0; tick();
    total++; if (occ !== 2'd1 || data_out !== 64'hC0) begin
      bad++; $display("FAIL stall_load got occ=%0d data=%0h want occ=1 data=c0", occ, data_out);
    end
    stall = 1; data_in = 64'hC4; tick();
    total++; if (occ !== 2'd2 || ready_out !== 1'b0 || data_out !== 64'hC0) begin
      bad++; $display("FAIL stall_skid got occ=%0d rdy=%0b data=%0h want occ=2 rdy=0 data=c0", occ, ready_out, data_out);
    end
    data_in = 64'hC8;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (occ !== 2'd2 || data_out !== 64'hC0 || valid_out !== 1'b1) begin
        bad++; $display("FAIL stall_hold_%0d got occ=%0d data=%0h want occ=2 data=c0", i, occ, data_out);
      end
    end
    stall = 0; tick();
    total++; if (occ !== 2'd1 || data_out !== 64'hC4 || ready_out !== 1'b1) begin
      bad++; $display("FAIL stall_rel1 got occ=%0d data=%0h rdy=%0b want occ=1 data=c4 rdy=1", occ, data_out, ready_out);
    end
    tick();
    total++; if (occ !== 2'd1 || data_out !== 64'hC8) begin
      bad++; $display("FAIL stall_rel2 got occ=%0d data=%0h want occ=1 data=c8", occ, data_out);
    end
    valid_in = 0; tick();
    total++; if (occ !== 2'd0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL stall_rel3 got occ=%0d v=%0b want 0 0", occ, valid_out);
    end
  endtask

  task automatic test_flush();
    idle(); ready_in = 0;
    valid_in = 1; data_in = 64'hD0; tick();
    data_in = 64'hD4; tick();
    valid_in = 1; data_in = 64'hB0; flush = 1; tick();
    total++; if (valid_out !== 1'b0 || occ !== 2'd0 || data_out !== RD || ready_out !== 1'b1) begin
      bad++; $display("FAIL flush_full got v=%0b occ=%0d data=%0h rdy=%0b want 0 0 dead 1", valid_out, occ, data_out, ready_out);
    end
    flush = 0; valid_in = 0; ready_in = 1; tick();
    total++; if (valid_out !== 1'b0 || data_out === 64'hB0) begin
      bad++; $display("FAIL flush_no_b0 got v=%0b data=%0h want v=0", valid_out, data_out);
    end
    // Flush while HALF with a live accept in the same cycle.
    ready_in = 0; valid_in = 1; data_in = 64'hE0; tick();
    data_in = 64'hE4; flush = 1; tick();
    total++; if (valid_out !== 1'b0 || occ !== 2'd0 || data_out !== RD) begin
      bad++; $display("FAIL flush_half got v=%0b occ=%0d data=%0h want 0 0 dead", valid_out, occ, data_out);
    end
    idle();
  endtask

  task automatic test_priority();
    idle(); ready_in = 0;
    valid_in = 1; data_in = 64'hF0; tick();
    data_in = 64'hF4; tick();
    total++; if (occ !== 2'd2) begin bad++; $display("FAIL prio_fill got occ=%0d want 2", occ); end
    rst = 1; flush = 1; tick();
    total++; if (valid_out !== 1'b0 || occ !== 2'd0 || data_out !== RD || ready_out !== 1'b1) begin
      bad++; $display("FAIL prio_reset got v=%0b occ=%0d data=%0h rdy=%0b want 0 0 dead 1", valid_out, occ, data_out, ready_out);
    end
    idle();
  endtask

  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] next_val;
    bit          in_f;
    bit          out_f;
    int          errs;
    idle(); tick();
    next_val = 64'h1000;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      if (!valid_in || ready_out) begin
        valid_in = ($urandom_range(0, 3) != 0);
        data_in  = next_val;
      end
      ready_in = ($urandom_range(0, 2) != 0);
      stall    = ($urandom_range(0, 5) == 0);
      in_f  = valid_in && ready_out;
      out_f = valid_out && ready_in && !stall;
      total++; if (valid_out !== (q.size() != 0)) begin
        bad++; errs++; $display("FAIL rand_valid c=%0d got=%0b want=%0b", c, valid_out, q.size() != 0);
      end
      if (out_f && q.size() != 0) begin
        total++; if (data_out !== q[0]) begin
          bad++; errs++; $display("FAIL rand_order c=%0d got=%0h want=%0h", c, data_out, q[0]);
        end
        void'(q.pop_front());
      end
      if (in_f) begin
        q.push_back(data_in);
        next_val = next_val + 64'h4;
      end
      tick();
      total++; if (occ !== 2'(q.size()) || ready_out !== (occ != 2'd2)) begin
        bad++; errs++; $display("FAIL rand_occ c=%0d got occ=%0d rdy=%0b want occ=%0d", c, occ, ready_out, q.size());
      end
      if (errs > 10) break;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_flush();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
